mult_seq_ctrl: RTL

//  Multi-cycle shift-add multiplier sequencer for the MIPS MULT/MULTU path.

---
 rtl/mult_seq_ctrl_if.sv | 27 ++
 rtl/mult_seq_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Purpose : operand/result bundle between the EX stage and the shift-add multiplier.
// Ports   : start/is_signed/op_a/op_b (request side), busy/done/hi/lo (result side).
// Flow    : master issues start while the sequencer is idle; slave reports busy and pulses done.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // EX-stage side: issues operands, watches status and results
    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    // Multiplier side
    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Purpose : MIPS MULT/MULTU shift-add multiplier sequencer; one adder reused WIDTH times.
// Latency : start at edge 0 -> done pulse in the cycle after edge WIDTH+2.
// Backpr. : no queueing; start is ignored unless idle, EX stage stalls on busy.
// Ports   : clk, reset (sync, active-high), bus (mult_seq_ctrl_if.slave).
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] lo_reg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    count_q;
    logic             neg_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] neg_prod_d;
    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic               neg_d;

    always_comb begin
        // Magnitudes: negating the signed minimum yields 2^(W-1), which is
        // exactly right when read back as an unsigned W-bit value.
        abs_a_d    = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        abs_b_d    = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        neg_d      = bus.is_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
        // One extra bit keeps the carry, which shifts into acc_hi's MSB.
        sum_d      = {1'b0, acc_hi_q} + (lo_reg_q[0] ? {1'b0, mcand_q} : '0);
        neg_prod_d = -{acc_hi_q, lo_reg_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            lo_reg_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= abs_a_d;
                        lo_reg_q <= abs_b_d;
                        acc_hi_q <= '0;
                        neg_q    <= neg_d;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    {acc_hi_q, lo_reg_q} <= {sum_d, lo_reg_q[WIDTH-1:1]};
                    count_q              <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (neg_q) begin
                        {acc_hi_q, lo_reg_q} <= neg_prod_d;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; the sequencer
                    // stays out of IDLE while done is high so a start seen
                    // alongside the done pulse is not taken.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        hi_q   <= acc_hi_q;
                        lo_q   <= lo_reg_q;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
